time_set_ctrl: RTL and testbench

- Upstream of the clock/timer/stopwatch mode-mux top level.
- Replaces the hard-coded set_hrs/set_min/set_sec registers with a button-driven time-setting state machine.
- Steps through hours, minutes and seconds fields. Inc/dec edits the selected field with wrap-around and hold-to-repeat.
- Pulses load_o on commit so the 12 h and 24 h clocks latch the new Hourset/Minset/Secset.
- Runs on the 1 kHz divided clock; its button inputs are already debounced.

---
 rtl/time_set_ctrl_pkg.sv | 27 ++
 rtl/btn_repeat.sv | 57 +++++
 rtl/time_set_ctrl.sv | 93 +++++++++
 tb/tb_time_set_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared types, limits and wrap helpers for the time-setting controller.
package time_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HRS  = 2'b01,
    ST_MIN  = 2'b10,
    ST_SEC  = 2'b11
  } state_t;

  localparam int unsigned HRS_W = 5;
  localparam int unsigned MS_W  = 6;

  localparam logic [HRS_W-1:0] HRS_MAX = 5'd23;
  localparam logic [MS_W-1:0]  MS_MAX  = 6'd59;

  function automatic logic [HRS_W-1:0] hrs_step(input logic [HRS_W-1:0] v, input logic up);
    if (up) return (v == HRS_MAX) ? '0 : v + 1'b1;
    return (v == '0) ? HRS_MAX : v - 1'b1;
  endfunction

  function automatic logic [MS_W-1:0] ms_step(input logic [MS_W-1:0] v, input logic up);
    if (up) return (v == MS_MAX) ? '0 : v + 1'b1;
    return (v == '0) ? MS_MAX : v - 1'b1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold-to-repeat counter for one edit button.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  input  logic other_i,
  input  logic active_i,
  input  logic clear_i,
  output logic step_o
);

  localparam int unsigned CW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] CNT_FIRE   = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE);

  logic          btn_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          rise;
  logic          solo;

  assign rise    = btn_i & ~btn_q;
  assign solo    = btn_i & ~other_i;
  assign cnt_inc = cnt + 1'b1;

  // After the first repeat fires, reloading at DELAY-RATE spaces later steps by RATE.
  always_comb begin
    step_o = 1'b0;
    cnt_d  = cnt;
    if (!active_i || clear_i || !solo) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d  = '0;
      step_o = 1'b1;
    end else if (cnt_inc == CNT_FIRE) begin
      cnt_d  = CNT_RELOAD;
      step_o = 1'b1;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      btn_q <= 1'b0;
      cnt   <= '0;
    end else begin
      btn_q <= btn_i;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting FSM: selects hrs/min/sec, edits with wrap, strobes load_o on commit.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int unsigned HRS_DEFAULT  = 17,
  parameter int unsigned MIN_DEFAULT  = 35,
  parameter int unsigned SEC_DEFAULT  = 42,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             btn_mode_i,
  input  logic             btn_inc_i,
  input  logic             btn_dec_i,
  output logic [HRS_W-1:0] set_hrs,
  output logic [MS_W-1:0]  set_min,
  output logic [MS_W-1:0]  set_sec,
  output logic             load_o,
  output logic [1:0]       edit_field_o
);

  state_t state;
  logic   mode_q;
  logic   mode_rise;
  logic   active;
  logic   inc_step;
  logic   dec_step;

  assign mode_rise    = btn_mode_i & ~mode_q;
  assign active       = (state != ST_IDLE);
  assign edit_field_o = state;

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_inc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (btn_inc_i),
    .other_i (btn_dec_i),
    .active_i(active),
    .clear_i (mode_rise),
    .step_o  (inc_step)
  );

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_dec (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (btn_dec_i),
    .other_i (btn_inc_i),
    .active_i(active),
    .clear_i (mode_rise),
    .step_o  (dec_step)
  );

  // inc_step and dec_step are mutually exclusive: each requires the other button released.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state   <= ST_IDLE;
      mode_q  <= 1'b0;
      load_o  <= 1'b0;
      set_hrs <= HRS_W'(HRS_DEFAULT);
      set_min <= MS_W'(MIN_DEFAULT);
      set_sec <= MS_W'(SEC_DEFAULT);
    end else begin
      mode_q <= btn_mode_i;
      load_o <= 1'b0;
      if (mode_rise) begin
        case (state)
          ST_IDLE: state <= ST_HRS;
          ST_HRS:  state <= ST_MIN;
          ST_MIN:  state <= ST_SEC;
          default: begin
            state  <= ST_IDLE;
            load_o <= 1'b1;
          end
        endcase
      end else if (inc_step || dec_step) begin
        case (state)
          ST_HRS:  set_hrs <= hrs_step(set_hrs, inc_step);
          ST_MIN:  set_min <= ms_step(set_min, inc_step);
          ST_SEC:  set_sec <= ms_step(set_sec, inc_step);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expectations queued at stimulus, checked after each edge.
module tb_time_set_ctrl;

  logic       clk;
  logic       reset_i;
  logic       btn_mode_i;
  logic       btn_inc_i;
  logic       btn_dec_i;
  logic [4:0] set_hrs;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       load_o;
  logic [1:0] edit_field_o;

  typedef struct {
    logic [4:0] hrs;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] field;
    logic       load;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   load_seen;
  int   m_hrs, m_min, m_sec, m_field;

  time_set_ctrl #(
    .HRS_DEFAULT (17),
    .MIN_DEFAULT (35),
    .SEC_DEFAULT (42),
    .REPEAT_DELAY(500),
    .REPEAT_RATE (100)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .btn_mode_i  (btn_mode_i),
    .btn_inc_i   (btn_inc_i),
    .btn_dec_i   (btn_dec_i),
    .set_hrs     (set_hrs),
    .set_min     (set_min),
    .set_sec     (set_sec),
    .load_o      (load_o),
    .edit_field_o(edit_field_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: one queued expectation per edge at which one was pushed.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (load_o === 1'b1) load_seen++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks += 5;
      if (set_hrs !== e.hrs) begin
        failures++;
        $display("FAIL sb_hrs got=%0d exp=%0d t=%0t", set_hrs, e.hrs, $time);
      end
      if (set_min !== e.min) begin
        failures++;
        $display("FAIL sb_min got=%0d exp=%0d t=%0t", set_min, e.min, $time);
      end
      if (set_sec !== e.sec) begin
        failures++;
        $display("FAIL sb_sec got=%0d exp=%0d t=%0t", set_sec, e.sec, $time);
      end
      if (edit_field_o !== e.field) begin
        failures++;
        $display("FAIL sb_field got=%0d exp=%0d t=%0t", edit_field_o, e.field, $time);
      end
      if (load_o !== e.load) begin
        failures++;
        $display("FAIL sb_load got=%0d exp=%0d t=%0t", load_o, e.load, $time);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic ld);
    exp_t e;
    e.hrs   = 5'(m_hrs);
    e.min   = 6'(m_min);
    e.sec   = 6'(m_sec);
    e.field = 2'(m_field);
    e.load  = ld;
    sb.push_back(e);
  endtask

  function automatic void bump(input bit up);
    case (m_field)
      1: m_hrs = up ? (m_hrs + 1) % 24 : (m_hrs + 23) % 24;
      2: m_min = up ? (m_min + 1) % 60 : (m_min + 59) % 60;
      3: m_sec = up ? (m_sec + 1) % 60 : (m_sec + 59) % 60;
      default: ;
    endcase
  endfunction

  // b: 0 = mode, 1 = inc, 2 = dec; one cycle high then one cycle low.
  task automatic press(input int b);
    logic ld;
    ld = 1'b0;
    case (b)
      0: begin
        btn_mode_i = 1'b1;
        if (m_field == 3) ld = 1'b1;
        m_field = (m_field + 1) % 4;
      end
      1: begin btn_inc_i = 1'b1; bump(1'b1); end
      default: begin btn_dec_i = 1'b1; bump(1'b0); end
    endcase
    push(ld);
    cyc(1);
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    btn_dec_i  = 1'b0;
    push(1'b0);
    cyc(1);
  endtask

  task automatic do_reset();
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    btn_dec_i  = 1'b0;
    reset_i    = 1'b0;
    cyc(2);
    reset_i = 1'b1;
    m_hrs = 17; m_min = 35; m_sec = 42; m_field = 0;
    cyc(1);
  endtask

  task automatic test_reset();
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    btn_dec_i  = 1'b0;
    reset_i    = 1'b0;
    cyc(2);
    reset_i = 1'b1;
    m_hrs = 17; m_min = 35; m_sec = 42; m_field = 0;
    push(1'b0);
    cyc(1);
    checks++;
    if (set_hrs !== 5'd17 || set_min !== 6'd35 || set_sec !== 6'd42 ||
        load_o !== 1'b0 || edit_field_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_state got=%0d/%0d/%0d load=%0d field=%0d exp=17/35/42 load=0 field=0",
               set_hrs, set_min, set_sec, load_o, edit_field_o);
    end
  endtask

  task automatic test_wrap();
    press(0);
    repeat (7) press(1);
    checks++;
    if (set_hrs !== 5'd0 || edit_field_o !== 2'b01) begin
      failures++;
      $display("FAIL wrap_up got hrs=%0d field=%0d exp hrs=0 field=1", set_hrs, edit_field_o);
    end
    press(2);
    checks++;
    if (set_hrs !== 5'd23) begin
      failures++;
      $display("FAIL wrap_down got hrs=%0d exp=23", set_hrs);
    end
  endtask

  task automatic test_full_cycle();
    int base;
    do_reset();
    press(0);
    press(0);
    repeat (36) press(2);
    checks++;
    if (set_min !== 6'd59) begin
      failures++;
      $display("FAIL min_wrap got=%0d exp=59", set_min);
    end
    press(0);
    repeat (18) press(1);
    checks++;
    if (set_sec !== 6'd0) begin
      failures++;
      $display("FAIL sec_wrap got=%0d exp=0", set_sec);
    end
    base = load_seen;
    press(0);
    cyc(3);
    checks++;
    if (load_seen - base != 1) begin
      failures++;
      $display("FAIL load_pulse_count got=%0d exp=1", load_seen - base);
    end
    checks++;
    if (set_hrs !== 5'd17 || set_min !== 6'd59 || set_sec !== 6'd0 || edit_field_o !== 2'b00) begin
      failures++;
      $display("FAIL commit_hold got=%0d/%0d/%0d field=%0d exp=17/59/0 field=0",
               set_hrs, set_min, set_sec, edit_field_o);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    press(0);
    press(0);
    btn_inc_i = 1'b1;
    bump(1'b1);
    push(1'b0);
    cyc(1);
    for (int k = 1; k <= 1000; k++) begin
      if (k >= 500 && (k - 500) % 100 == 0) bump(1'b1);
      if (k == 499 || k == 501 || (k >= 500 && (k % 100 == 0 || k % 100 == 99)))
        push(1'b0);
      cyc(1);
    end
    btn_inc_i = 1'b0;
    push(1'b0);
    cyc(2);
    checks++;
    if (set_min !== 6'd42) begin
      failures++;
      $display("FAIL repeat_total got=%0d exp=42", set_min);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(0);
    btn_dec_i = 1'b1;
    bump(1'b0);
    push(1'b0);
    cyc(1);
    btn_inc_i = 1'b1;
    repeat (4) begin
      push(1'b0);
      cyc(1);
    end
    checks++;
    if (set_hrs !== 5'd16) begin
      failures++;
      $display("FAIL both_held got hrs=%0d exp=16", set_hrs);
    end
    btn_inc_i = 1'b0;
    btn_dec_i = 1'b0;
    push(1'b0);
    cyc(1);
    btn_mode_i = 1'b1;
    btn_inc_i  = 1'b1;
    m_field = 2;
    push(1'b0);
    cyc(1);
    push(1'b0);
    cyc(1);
    checks++;
    if (edit_field_o !== 2'b10 || set_hrs !== 5'd16 || set_min !== 6'd35) begin
      failures++;
      $display("FAIL mode_wins got field=%0d hrs=%0d min=%0d exp field=2 hrs=16 min=35",
               edit_field_o, set_hrs, set_min);
    end
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset_mid_edit();
    int base;
    do_reset();
    press(0);
    press(0);
    press(0);
    repeat (28) press(1);
    checks++;
    if (set_sec !== 6'd10 || edit_field_o !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset got sec=%0d field=%0d exp sec=10 field=3", set_sec, edit_field_o);
    end
    base = load_seen;
    reset_i = 1'b0;
    cyc(1);
    checks++;
    if (set_sec !== 6'd42 || edit_field_o !== 2'b00 || load_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got sec=%0d field=%0d load=%0d exp sec=42 field=0 load=0",
               set_sec, edit_field_o, load_o);
    end
    cyc(1);
    reset_i = 1'b1;
    cyc(3);
    checks++;
    if (load_seen != base) begin
      failures++;
      $display("FAIL reset_no_load got=%0d exp=0", load_seen - base);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    load_seen  = 0;
    reset_i    = 1'b0;
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    btn_dec_i  = 1'b0;
    test_reset();
    test_wrap();
    test_full_cycle();
    test_repeat();
    test_simultaneous();
    test_reset_mid_edit();
    cyc(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
